// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: instruction width, special encodings
// and the fetch controller state type.
package riscv_pkg;

  localparam int ILEN = 32;

  // addi x0,x0,0 -- presented on the IF/ID register whenever it holds nothing
  localparam logic [ILEN-1:0] NOP_INST    = 32'h0000_0013;
  // ebreak -- stops further fetching once it has been delivered
  localparam logic [ILEN-1:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit32_if.sv
// Fetch-stage bus: the instruction-memory lookup on one side and the
// IF/ID valid/ready handshake on the other. The fetch unit is the master.
interface fetch_unit32_if #(
  parameter int n = 32
);

  logic [n-1:0] imem_addr;
  logic [n-1:0] imem_inst;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_inst;
  logic [n-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_inst,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/pc_reg32.sv
// Program counter: reset value, +4 sequential advance and redirect mux.
// The PC is kept word aligned; the low two bits of any target are dropped.
module pc_reg32 #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  output logic [n-1:0] pc
);

  // Redirect wins over sequential advance; the +4 wraps naturally at 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours, exactly like the flops it models.
    if (!rst_n) begin
      pc <= {RESET_PC[n-1:2], 2'b00};
    end else if (redirect_valid) begin
      pc <= {redirect_pc[n-1:2], 2'b00};
    end else if (advance) begin
      pc <= pc + n'(4);
    end
  end

endmodule

// File: rtl/fetch_unit32.sv
// Instruction fetch stage: drives the PC to inst_memory32, captures the
// combinationally returned word into an IF/ID register with a valid/ready
// handshake, handles redirect/flush, halts after delivering EBREAK, and
// counts completed handshakes.
module fetch_unit32 #(
  parameter int           n           = riscv_pkg::ILEN,
  parameter logic [n-1:0] RESET_PC    = '0,
  parameter logic [n-1:0] NOP_INST    = riscv_pkg::NOP_INST,
  parameter logic [n-1:0] EBREAK_INST = riscv_pkg::EBREAK_INST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  fetch_unit32_if.master bus,
  output logic         halted,
  output logic [n-1:0] fetch_count
);

  import riscv_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;
  logic [n-1:0] pc;
  logic         fire;
  logic         slot_free;
  logic         capture;
  logic         is_ebreak;

  // Handshake bookkeeping: a transfer happens on fire; the output register
  // can take a new word when empty or when its current word is leaving.
  assign fire      = bus.out_valid & bus.out_ready;
  assign slot_free = ~bus.out_valid | bus.out_ready;
  assign is_ebreak = (bus.imem_inst == EBREAK_INST);

  // A redirect cycle never captures: the word on imem_inst belongs to the
  // old path, and the target is looked up on the following cycle.
  assign capture = (state == RUN) & en & slot_free & ~redirect_valid;

  assign bus.imem_addr = pc;
  assign halted        = (state == HALT);

  pc_reg32 #(
    .n        (n),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (capture),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  // Next-state logic: redirect always lands in RUN, BOOT lasts one cycle,
  // and delivering an EBREAK parks the controller in HALT.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        BOOT:    state_next = RUN;
        RUN:     if (capture && is_ebreak) state_next = HALT;
        HALT:    state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // IF/ID output register: flush on redirect, load on capture, empty on a
  // transfer with nothing behind it, otherwise hold (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= NOP_INST;
      bus.out_pc    <= '0;
    end else if (redirect_valid) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= NOP_INST;
    end else if (capture) begin
      bus.out_valid <= 1'b1;
      bus.out_inst  <= bus.imem_inst;
      bus.out_pc    <= pc;
    end else if (fire) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= NOP_INST;
    end
  end

  // Delivered-instruction counter; a transfer seen by the consumer counts
  // even if a redirect flushes the stage in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fetch_count <= '0;
    else if (fire) fetch_count <= fetch_count + n'(1);
  end

endmodule

// File: tb/tb_fetch_unit32.sv
// Self-checking bench for fetch_unit32: directed scenarios followed by
// randomized en/ready/redirect traffic, compared each cycle against a
// transaction-level model of the fetch stage.
module tb_fetch_unit32;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the program counter, the single output slot and the
  // delivered count, plus whether we are in the post-reset idle cycle or halted.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_opc;
  logic [31:0] m_count;
  logic        m_booting;
  logic        m_halted;

  fetch_unit32_if #(.n(32)) bus ();

  assign bus.out_ready = out_ready;
  assign bus.imem_inst = mem[bus.imem_addr[7:2]];

  fetch_unit32 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_valid   = 1'b0;
    m_inst    = NOP;
    m_opc     = 32'h0;
    m_count   = 32'h0;
    m_booting = 1'b1;
    m_halted  = 1'b0;
  endtask

  task automatic compare_all();
    check("out_valid",   {31'b0, bus.out_valid}, {31'b0, m_valid});
    check("out_inst",    bus.out_inst, m_inst);
    if (m_valid) check("out_pc", bus.out_pc, m_opc);
    check("imem_addr",   bus.imem_addr, m_pc);
    check("halted",      {31'b0, halted}, {31'b0, m_halted});
    check("fetch_count", fetch_count, m_count);
  endtask

  // Advance the model by one cycle from the current inputs, then clock the
  // DUT and compare just after the edge.
  task automatic cycle();
    logic        fire;
    logic        room;
    logic [31:0] word;
    fire = m_valid && out_ready;
    room = !m_valid || out_ready;
    word = mem[m_pc[7:2]];
    if (fire) m_count = m_count + 1;
    if (redirect_valid) begin
      m_pc      = redirect_pc & ~32'h3;
      m_valid   = 1'b0;
      m_inst    = NOP;
      m_booting = 1'b0;
      m_halted  = 1'b0;
    end else if (!m_booting && !m_halted && en && room) begin
      m_inst  = word;
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      if (word == EBREAK) m_halted = 1'b1;
    end else begin
      if (fire) begin
        m_valid = 1'b0;
        m_inst  = NOP;
      end
      m_booting = 1'b0;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst_n          = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == EBREAK) w = w ^ 32'h1;
      mem[i] = w;
    end
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_out_pc", bus.out_pc, 32'h0);
    rst_n     = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;

    // Boot cycle, then a straight-line stream at full rate
    cycle();
    check("boot_idle", {31'b0, bus.out_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stream_pc",   bus.out_pc, 32'(i * 4));
      check("stream_inst", bus.out_inst, mem[i]);
    end
    cycle();
    check("count_after_5", fetch_count, 32'd5);

    // Backpressure with word 2 held in the output register
    redirect_to(32'h0);
    repeat (3) cycle();
    check("bp_pc_before", bus.out_pc, 32'h8);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_pc",   bus.out_pc, 32'h8);
      check("bp_hold_inst", bus.out_inst, mem[2]);
      check("bp_hold_addr", bus.imem_addr, 32'hC);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_resume_12", bus.out_pc, 32'hC);
    cycle();
    check("bp_resume_16", bus.out_pc, 32'h10);

    // Redirect to an unaligned target while holding a valid word
    redirect_to(32'h0000_0043);
    check("redir_flush", {31'b0, bus.out_valid}, 32'h0);
    check("redir_addr",  bus.imem_addr, 32'h40);
    cycle();
    check("redir_first", bus.out_pc, 32'h40);

    // EBREAK at address 12 halts the stage after delivery
    mem[3] = EBREAK;
    redirect_to(32'h0);
    repeat (4) cycle();
    check("ebreak_pc",   bus.out_pc, 32'hC);
    check("ebreak_inst", bus.out_inst, EBREAK);
    check("ebreak_halt", {31'b0, halted}, 32'h1);
    repeat (4) begin
      cycle();
      check("halt_no_fetch", {31'b0, bus.out_valid}, 32'h0);
    end
    redirect_to(32'h0);
    check("halt_cleared", {31'b0, halted}, 32'h0);
    cycle();
    check("resume_pc", bus.out_pc, 32'h0);
    mem[3] = 32'h1234_5678;

    // PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    cycle();
    check("wrap_top", bus.out_pc, 32'hFFFF_FFFC);
    cycle();
    check("wrap_zero", bus.out_pc, 32'h0);

    // Randomized traffic, with a couple of EBREAKs in the image
    mem[20] = EBREAK;
    mem[45] = EBREAK;
    for (int i = 0; i < 600; i++) begin
      en             = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 63) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 255));
      cycle();
    end
    redirect_valid = 1'b0;
    en             = 1'b1;
    out_ready      = 1'b1;
    redirect_to(32'h0);
    repeat (3) cycle();

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("async_rst_count", fetch_count, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("rst_boot_idle", {31'b0, bus.out_valid}, 32'h0);
    cycle();
    check("rst_restart_pc", bus.out_pc, 32'h0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
